// File: rtl/avalon_led_ctrl.sv
// rtl/avalon_led_ctrl.sv - Avalon-MM LED/PIO controller with set/clr/toggle, blink timebase and global PWM
module avalon_led_ctrl #(
  parameter int NUM_LEDS     = 4,
  parameter int PRESCALE_DIV = 50000,
  parameter int PWM_W        = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [2:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic [NUM_LEDS-1:0] out_port
);

  localparam int                PS_W     = (PRESCALE_DIV > 2) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(PRESCALE_DIV - 1);
  localparam logic [PWM_W-1:0]  PWM_FULL = '1;
  localparam logic [15:0]       PERIOD_RST = 16'd500;

  logic [NUM_LEDS-1:0] data_q, data_d;
  logic [NUM_LEDS-1:0] mode_q, mode_d;
  logic [NUM_LEDS-1:0] out_q, out_d;
  logic [15:0]         period_q, period_d;
  logic [15:0]         blink_cnt_q, blink_cnt_d;
  logic [PWM_W-1:0]    bright_q, bright_d;
  logic [PWM_W-1:0]    pwm_cnt_q, pwm_cnt_d;
  logic [PS_W-1:0]     presc_q, presc_d;
  logic                phase_q, phase_d;

  logic                wr_en;
  logic                period_wr;
  logic                tick;
  logic                pwm_on;
  logic [NUM_LEDS-1:0] wd_leds;
  logic                unused_wdata;

  assign wr_en        = chipselect && !write_n;
  assign period_wr    = wr_en && (address == 3'd5);
  assign wd_leds      = writedata[NUM_LEDS-1:0];
  assign unused_wdata = ^writedata;
  assign out_port     = out_q;

  // Register file updates: static data with atomic set/clear/toggle, mode, period, brightness
  always_comb begin
    data_d   = data_q;
    mode_d   = mode_q;
    period_d = period_q;
    bright_d = bright_q;
    if (wr_en) begin
      case (address)
        3'd0: data_d   = wd_leds;
        3'd1: data_d   = data_q | wd_leds;
        3'd2: data_d   = data_q & ~wd_leds;
        3'd3: data_d   = data_q ^ wd_leds;
        3'd4: mode_d   = wd_leds;
        3'd5: period_d = writedata[15:0];
        3'd6: bright_d = writedata[PWM_W-1:0];
        default: ;
      endcase
    end
  end

  // Prescaled tick, blink half-period counter and phase; a period write restarts the blink
  always_comb begin
    tick        = (presc_q == PS_LAST);
    presc_d     = tick ? '0 : presc_q + PS_W'(1);
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (period_wr) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (tick) begin
      if (period_q == 16'd0) begin
        blink_cnt_d = '0;
      end else if (blink_cnt_q >= period_q - 16'd1) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 16'd1;
      end
    end
  end

  // Free-running PWM with a true 100% duty at full brightness, then the combined LED drive
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
    pwm_on    = (bright_q == PWM_FULL) || (pwm_cnt_q < bright_q);
    out_d     = data_q & (~mode_q | {NUM_LEDS{phase_q}}) & {NUM_LEDS{pwm_on}};
  end

  // Zero-latency read mux; write-only and unmapped bits read as zero
  always_comb begin
    readdata = '0;
    case (address)
      3'd0: readdata = 32'(data_q);
      3'd4: readdata = 32'(mode_q);
      3'd5: readdata = 32'(period_q);
      3'd6: readdata = 32'(bright_q);
      3'd7: readdata = {blink_cnt_q, 14'd0, tick, phase_q};
      default: readdata = '0;
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q      <= '0;
      mode_q      <= '0;
      period_q    <= PERIOD_RST;
      bright_q    <= PWM_FULL;
      presc_q     <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      pwm_cnt_q   <= '0;
      out_q       <= '0;
    end else begin
      data_q      <= data_d;
      mode_q      <= mode_d;
      period_q    <= period_d;
      bright_q    <= bright_d;
      presc_q     <= presc_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      pwm_cnt_q   <= pwm_cnt_d;
      out_q       <= out_d;
    end
  end

endmodule

// File: tb/tb_avalon_led_ctrl.sv
// tb/tb_avalon_led_ctrl.sv - self-checking bench for avalon_led_ctrl
module tb_avalon_led_ctrl;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [2:0]   address = '0;
  logic         chipselect = 1'b0;
  logic         write_n = 1'b1;
  logic [31:0]  writedata = '0;
  logic [31:0]  readdata;
  logic [N-1:0] out_port;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        wr;
    logic [2:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  raddr;
    logic [31:0] exp_rd;
    logic [3:0]  exp_out;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  avalon_led_ctrl #(.NUM_LEDS(N), .PRESCALE_DIV(4), .PWM_W(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  function automatic vec_t mkv(string n, logic w, logic [2:0] wa, logic [31:0] wd,
                               logic [2:0] ra, logic [31:0] er, logic [3:0] eo);
    vec_t v;
    v.name = n; v.wr = w; v.waddr = wa; v.wdata = wd;
    v.raddr = ra; v.exp_rd = er; v.exp_out = eo;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    address = 3'd7;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      #1;
      if (readdata[1]) begin
        ok = 1'b1;
        break;
      end
    end
    check("tick_seen", 32'(ok), 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    vec_t        v, e;
    bit          ok;
    int          bad, on;
    logic        prev;
    int          chg[$];

    vecs.push_back(mkv("rst_bright", 0, 0, 0,            6, 32'hF,    4'h0));
    vecs.push_back(mkv("rst_period", 0, 0, 0,            5, 32'd500,  4'h0));
    vecs.push_back(mkv("rst_mode",   0, 0, 0,            4, 32'h0,    4'h0));
    vecs.push_back(mkv("data_a",     1, 0, 32'hA,        0, 32'hA,    4'hA));
    vecs.push_back(mkv("data_3",     1, 0, 32'h3,        0, 32'h3,    4'h3));
    vecs.push_back(mkv("set_4",      1, 1, 32'h4,        0, 32'h7,    4'h7));
    vecs.push_back(mkv("clr_1",      1, 2, 32'h1,        0, 32'h6,    4'h6));
    vecs.push_back(mkv("tog_f",      1, 3, 32'hF,        0, 32'h9,    4'h9));
    vecs.push_back(mkv("rd_set",     0, 0, 0,            1, 32'h0,    4'h9));
    vecs.push_back(mkv("rd_clr",     0, 0, 0,            2, 32'h0,    4'h9));
    vecs.push_back(mkv("rd_tog",     0, 0, 0,            3, 32'h0,    4'h9));
    vecs.push_back(mkv("data_hi",    1, 0, 32'hFFFFFFF0, 0, 32'h0,    4'h0));
    vecs.push_back(mkv("mode_trunc", 1, 4, 32'hFFFFFFF5, 4, 32'h5,    4'h0));
    vecs.push_back(mkv("mode_0",     1, 4, 32'h0,        4, 32'h0,    4'h0));
    vecs.push_back(mkv("bright_trn", 1, 6, 32'h1F3,      6, 32'h3,    4'h0));
    vecs.push_back(mkv("bright_f",   1, 6, 32'hF,        6, 32'hF,    4'h0));
    vecs.push_back(mkv("period_trn", 1, 5, 32'h12345,    5, 32'h2345, 4'h0));
    vecs.push_back(mkv("data_c",     1, 0, 32'hC,        0, 32'hC,    4'hC));

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out", 32'(out_port), 32'h0);
    reset_n = 1'b1;

    // Table-driven register accesses with a scoreboard queue
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.wr) bus_write(v.waddr, v.wdata);
      else      @(negedge clk);
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check({e.name, "_out"}, 32'(out_port), 32'(e.exp_out));
      rd(e.raddr, r);
      check({e.name, "_rd"}, r, e.exp_rd);
    end

    // Writes without chipselect or with write_n high are ignored
    bus_write(0, 32'h5);
    @(negedge clk);
    address = 3'd0; writedata = 32'hA; chipselect = 1'b0; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; writedata = '0;
    rd(0, r);
    check("no_write", r, 32'h5);

    // Tick status bit lasts one cycle
    wait_tick(ok);
    check("tick_bit", 32'(readdata[1]), 32'd1);
    @(negedge clk);
    #1;
    check("tick_one_cycle", 32'(readdata[1]), 32'd0);

    // Blink: half-period 2 ticks of 4 clk -> toggle every 8 clk
    bus_write(4, 32'h1);
    bus_write(0, 32'h1);
    bus_write(5, 32'h2);
    @(posedge clk); #1;
    prev = out_port[0];
    for (int i = 0; i < 48; i++) begin
      @(posedge clk); #1;
      if (out_port[0] !== prev) begin
        chg.push_back(i);
        prev = out_port[0];
      end
    end
    check("blink_edges", 32'(chg.size() >= 4), 32'd1);
    for (int k = 1; k < chg.size(); k++)
      check("blink_interval", 32'(chg[k] - chg[k-1]), 32'd8);

    // Period 0 freezes the blink with phase on
    bus_write(5, 32'h0);
    @(posedge clk); #1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_port !== 4'h1) bad++;
    end
    check("period0_frozen", 32'(bad), 32'd0);
    rd(7, r);
    check("period0_status", r & 32'hFFFF0001, 32'h1);

    // Period write coincident with a tick overrides the tick
    bus_write(5, 32'h2);
    wait_tick(ok);
    wait_tick(ok);
    wait_tick(ok);
    check("pre_coincide", readdata, 32'h2);
    address = 3'd5; writedata = 32'h2; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    rd(7, r);
    check("coincide_status", r, 32'h1);

    // PWM duty: 4/16, 100%, 0%
    bus_write(4, 32'h0);
    bus_write(0, 32'hF);
    bus_write(6, 32'h4);
    @(posedge clk);
    on = 0; bad = 0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      if (out_port === 4'hF) on++;
      else if (out_port !== 4'h0) bad++;
    end
    check("pwm4_on", 32'(on), 32'd16);
    check("pwm4_values", 32'(bad), 32'd0);
    bus_write(6, 32'hF);
    @(posedge clk);
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      if (out_port !== 4'hF) bad++;
    end
    check("pwm_full", 32'(bad), 32'd0);
    bus_write(6, 32'h0);
    @(posedge clk);
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      if (out_port !== 4'h0) bad++;
    end
    check("pwm_zero", 32'(bad), 32'd0);

    // Asynchronous reset mid-blink
    bus_write(6, 32'hF);
    bus_write(4, 32'hF);
    bus_write(5, 32'h2);
    @(posedge clk); #1;
    check("pre_reset_out", 32'(out_port), 32'hF);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_out", 32'(out_port), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(0, r); check("post_rst_data", r, 32'h0);
    rd(4, r); check("post_rst_mode", r, 32'h0);
    rd(5, r); check("post_rst_period", r, 32'd500);
    rd(6, r); check("post_rst_bright", r, 32'hF);
    rd(7, r); check("post_rst_status", r, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/avalon_led_ctrl.md
Name: avalon_led_ctrl

Overview:
Parametrised Avalon-MM slave LED/PIO output controller, successor to the fixed 4-bit LED register.
- NUM_LEDS output channels with atomic set/clear/toggle access.
- Per-channel blink mode driven by a shared prescaled timebase, plus a global PWM brightness.
- Sits on the HPS-to-FPGA lightweight bridge and drives board LEDs directly.

Parameters:
NUM_LEDS, 4, number of output channels (1..32)
PRESCALE_DIV, 50000, clk cycles per blink tick (>=2); 1 ms at 50 MHz
PWM_W, 8, brightness/PWM counter width (2..16)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
address  input  3  word address
chipselect  input  1  slave select
write_n  input  1  active-low write strobe
writedata  input  32  write data
readdata  output  32  read data, zero-wait, combinational from address
out_port  output  NUM_LEDS  registered LED drive

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. While in reset:
  - DATA=0, MODE=0, BLINK_PERIOD=500, BRIGHTNESS=all ones.
  - prescaler=0, blink counter=0, phase=1, pwm counter=0, out_port=0.
- Write: accepted when chipselect && !write_n on a clk edge. Bits above NUM_LEDS (or above a field width) are ignored; reads return them as 0.
- Register map (word address):
  - 0 DATA R/W: static on/off per channel.
  - 1 SET W: DATA |= wd. Reads 0.
  - 2 CLR W: DATA &= ~wd. Reads 0.
  - 3 TOGGLE W: DATA ^= wd. Reads 0.
  - 4 MODE R/W: bit i=1 puts channel i in blink mode.
  - 5 BLINK_PERIOD R/W [15:0]: half-period in ticks.
  - 6 BRIGHTNESS R/W [PWM_W-1:0]: global duty.
  - 7 STATUS R: [0]=blink phase, [1]=tick pulse (current cycle), [31:16]=blink counter.
- Read: readdata = selected register, same cycle (read latency 0). No side effects on read.
- Prescaler:
  - Counts 0..PRESCALE_DIV-1 and wraps.
  - tick=1 for exactly one cycle when the count equals PRESCALE_DIV-1.
- Blink counter:
  - On tick, if counter >= BLINK_PERIOD-1: counter=0 and phase toggles. Otherwise counter+1.
  - BLINK_PERIOD=0: counter held at 0, phase frozen.
  - A write to BLINK_PERIOD clears the counter and sets phase=1 in that cycle, overriding a coincident tick.
- PWM:
  - Free-running PWM_W-bit counter, +1 every clk, wraps.
  - pwm_on = (pwm_cnt < BRIGHTNESS), except BRIGHTNESS = all ones forces pwm_on=1 (true 100%).
  - BRIGHTNESS=0 gives all channels off.
- Output:
  - out_port[i] <= DATA[i] & (MODE[i] ? phase : 1) & pwm_on, registered.
  - Latency from a DATA/SET/CLR/TOGGLE write edge to out_port change is 1 clk (register updates at edge N, out_port at edge N+1).
- Simultaneous events: only one register write per cycle, so no set/clear conflict is possible. A tick and a MODE write in the same cycle are both applied.
- Reset asserted mid-operation: all state returns to reset values asynchronously; out_port goes 0 immediately.
- Backward compatibility: with default MODE/BRIGHTNESS, a write to address 0 gives the same software behaviour as the legacy LED register, with +1 clk output latency.

Test Plan:
1. Reset, NUM_LEDS=4 -> out_port=0; read addr 6=0xFF, addr 5=500. Write DATA=0xA -> out_port=0xA one clk after write edge; read addr 0=0xA.
2. DATA=0x3; SET 0x4 -> 0x7; CLR 0x1 -> 0x6; TOGGLE 0xF -> 0x9. Read addr 1/2/3 -> 0. Write 0xFFFFFFF0 to DATA -> DATA=0x0.
3. PRESCALE_DIV=4, BLINK_PERIOD=2, MODE=0x1, DATA=0x1 -> out_port[0] toggles every 8 clk. BLINK_PERIOD=0 -> out_port[0] frozen. Rewrite BLINK_PERIOD=2 coincident with tick -> phase=1, counter=0.
4. PWM_W=4, BRIGHTNESS=4, DATA=0xF -> out_port=0xF for 4 of every 16 clk. BRIGHTNESS=15 -> constant 0xF. BRIGHTNESS=0 -> constant 0.
5. Assert reset_n low mid-blink with DATA=0xF -> out_port=0 the same cycle without a clk edge. After release, registers are back at defaults.
6. Write with chipselect=0 or write_n=1 -> no register change. Read addr 7 with tick forced -> bit1=1 for one cycle only.
